// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer: FSM states,
// register offsets within the 3-word window, STATUS bit positions, HTRANS codes.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PIX,
    ST_SHIFT,
    ST_CONV,
    ST_WAIT_DONE,
    ST_FRAME_DONE
  } seq_state_t;

  localparam logic [3:0] PIXEL_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;
  localparam logic [31:0] WINDOW_BYTES = 32'd12;

  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ACCEPT_BIT = 2;
  localparam int STAT_COUNT_LSB  = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// AHB-Lite slave-side signal bundle; HREADY is the bus-level ready from the fabric.
interface sobel_frame_sequencer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/sobel_ahb_if.sv
// AHB-Lite front end: captures the address phase, decodes the data phase,
// muxes STATUS onto HRDATA and stalls PIXEL writes while the datapath is busy.
module sobel_ahb_if
  import sobel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0020
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  sobel_frame_sequencer_if.slave  bus,
  input  logic                    stall_i,
  input  logic [31:0]             status_i,
  output logic                    pixel_wr_o,
  output logic [7:0]              pixel_o,
  output logic                    start_o
);

  logic        dp_hit_q, dp_hit_d;
  logic        dp_write_q, dp_write_d;
  logic [3:0]  dp_ofs_q, dp_ofs_d;
  logic [31:0] addr_ofs;
  logic        pixel_phase;

  assign addr_ofs = bus.HADDR - BASE_ADDR;

  // The data-phase registers only advance when the bus as a whole is ready,
  // so a stalled PIXEL write keeps its decode until it completes.
  always_comb begin
    dp_hit_d   = dp_hit_q;
    dp_write_d = dp_write_q;
    dp_ofs_d   = dp_ofs_q;
    if (bus.HREADY) begin
      dp_hit_d   = bus.HSEL & bus.HTRANS[1] & (addr_ofs < WINDOW_BYTES);
      dp_write_d = bus.HWRITE;
      dp_ofs_d   = addr_ofs[3:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_hit_q   <= 1'b0;
      dp_write_q <= 1'b0;
      dp_ofs_q   <= 4'h0;
    end else begin
      dp_hit_q   <= dp_hit_d;
      dp_write_q <= dp_write_d;
      dp_ofs_q   <= dp_ofs_d;
    end
  end

  assign pixel_phase   = dp_hit_q & dp_write_q & (dp_ofs_q == PIXEL_OFS);
  assign bus.HREADYOUT = ~(pixel_phase & stall_i);
  assign bus.HRESP     = 1'b0;
  assign bus.HRDATA    = (dp_hit_q & ~dp_write_q & (dp_ofs_q == STATUS_OFS)) ? status_i : 32'h0;

  assign pixel_wr_o = pixel_phase & ~stall_i;
  assign pixel_o    = bus.HWDATA[7:0];
  assign start_o    = dp_hit_q & dp_write_q & (dp_ofs_q == CTRL_OFS) & bus.HWDATA[0];

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.HWDATA[31:8], bus.HTRANS[0], addr_ofs[31:4]};

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame state machine: pushes each pixel into the image buffer, fires a
// convolution once a 3x3 window is complete and waits for the MCU to finish.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int          IMG_WIDTH  = 32,
  parameter int          IMG_HEIGHT = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0020
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  sobel_frame_sequencer_if.slave  bus,
  output logic                    shift_data,
  output logic [7:0]              pixel_out,
  output logic                    convolve_start,
  input  logic                    conv_done,
  output logic                    frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  seq_state_t       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       pix_q, pix_d;
  logic             last_q, last_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      conv_count_q, conv_count_d;

  logic        pixel_wr;
  logic [7:0]  pixel_in;
  logic        start_req;
  logic        stall;
  logic [31:0] status;

  assign stall = (state_q == ST_SHIFT) || (state_q == ST_CONV) || (state_q == ST_WAIT_DONE);

  always_comb begin
    status = 32'h0;
    status[STAT_BUSY_BIT]   = (state_q != ST_IDLE) && (state_q != ST_FRAME_DONE);
    status[STAT_DONE_BIT]   = frame_done_q;
    status[STAT_ACCEPT_BIT] = (state_q == ST_WAIT_PIX);
    status[STAT_COUNT_LSB +: 16] = conv_count_q;
  end

  sobel_ahb_if #(.BASE_ADDR(BASE_ADDR)) u_ahb (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (bus),
    .stall_i    (stall),
    .status_i   (status),
    .pixel_wr_o (pixel_wr),
    .pixel_o    (pixel_in),
    .start_o    (start_req)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pix_d        = pix_q;
    last_d       = last_q;
    frame_done_d = frame_done_q;
    conv_count_d = conv_count_q;
    case (state_q)
      ST_IDLE, ST_FRAME_DONE: begin
        if (start_req) begin
          col_d        = '0;
          row_d        = '0;
          last_d       = 1'b0;
          frame_done_d = 1'b0;
          conv_count_d = 16'h0;
          state_d      = ST_WAIT_PIX;
        end
      end
      ST_WAIT_PIX: begin
        if (pixel_wr) begin
          pix_d   = pixel_in;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Decisions use the position of the pixel being shifted, before the increment.
        last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
        if ((row_q >= ROW_TWO) && (col_q >= COL_TWO)) state_d = ST_CONV;
        else if (last_d)                              state_d = ST_FRAME_DONE;
        else                                          state_d = ST_WAIT_PIX;
      end
      ST_CONV: begin
        conv_count_d = sat_inc16(conv_count_q);
        state_d      = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (conv_done) state_d = last_q ? ST_FRAME_DONE : ST_WAIT_PIX;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FRAME_DONE) frame_done_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pix_q        <= 8'h0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      conv_count_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pix_q        <= pix_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      conv_count_q <= conv_count_d;
    end
  end

  assign shift_data     = (state_q == ST_SHIFT);
  assign convolve_start = (state_q == ST_CONV);
  assign pixel_out      = pix_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Self-checking bench for sobel_frame_sequencer on a 4x4 frame: register table,
// pixel/convolution scoreboard, stall timing, ignored events and mid-frame reset.
module tb_sobel_frame_sequencer;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [31:0] BASE   = 32'h0000_0020;
  localparam logic [31:0] A_PIX  = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_OUT  = BASE + 32'hC;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       shift_data, convolve_start, frame_done;
  logic       conv_done = 1'b0;
  logic [7:0] pixel_out;

  sobel_frame_sequencer_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  sobel_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BASE_ADDR(BASE)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .bus            (bus),
    .shift_data     (shift_data),
    .pixel_out      (pixel_out),
    .convolve_start (convolve_start),
    .conv_done      (conv_done),
    .frame_done     (frame_done)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Scoreboard: pixels expected on shift_data, and the pixel each convolve_start should follow.
  logic [7:0] exp_pix_q[$];
  logic [7:0] exp_conv_q[$];
  logic [7:0] last_shift = 8'h0;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (shift_data) begin
        if (exp_pix_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_shift: got pixel 0x%02h, expected no pulse", pixel_out);
        end else begin
          check("shift_pixel", {24'h0, pixel_out}, {24'h0, exp_pix_q.pop_front()});
        end
        last_shift = pixel_out;
      end
      if (convolve_start) begin
        if (exp_conv_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_conv: got pulse after 0x%02h, expected none", last_shift);
        end else begin
          check("conv_after_pixel", {24'h0, last_shift}, {24'h0, exp_conv_q.pop_front()});
        end
      end
    end
  end

  // MCU model: answers each convolve_start with a one-cycle conv_done after conv_delay cycles.
  int conv_delay = 3;
  int resp_epoch = 0;
  int done_cycle = -1;

  task automatic respond(input int ep);
    for (int k = 0; k < conv_delay; k++) begin
      @(posedge HCLK);
      if (ep != resp_epoch) return;
    end
    #1;
    if (ep != resp_epoch) return;
    conv_done = 1'b1;
    done_cycle = cyc;
    @(posedge HCLK);
    #1 conv_done = 1'b0;
  endtask

  always @(negedge HCLK) begin
    if (HRESETn && convolve_start) begin
      fork
        respond(resp_epoch);
      join_none
    end
  end

  // Non-pipelined single transfer; called and returns 1 time unit after a rising edge.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int stalls, output int done_cyc);
    stalls = 0;
    rdata = 32'h0;
    done_cyc = -1;
    bus.HSEL = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR = addr;
    bus.HWRITE = wr;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = wdata;
    for (int k = 0; k < 300; k++) begin
      @(negedge HCLK);
      if (bus.HREADYOUT) begin
        rdata = bus.HRDATA;
        done_cyc = cyc;
        @(posedge HCLK); #1;
        return;
      end
      stalls++;
      @(posedge HCLK); #1;
    end
    n_cmp++; n_fail++;
    $display("FAIL xfer_timeout: addr 0x%08h still stalled after 300 cycles, expected completion", addr);
  endtask

  // mode 0: plain frame; mode 1: check exact stall release after 0x0A;
  // mode 2: stray conv_done in WAIT_PIX and a CTRL start during WAIT_DONE.
  task automatic run_frame(input int mode);
    logic [31:0] rd;
    int st, dc;
    logic [7:0] p;
    for (int i = 0; i < W * H; i++) begin
      p = 8'(i);
      exp_pix_q.push_back(p);
      if ((i / W) >= 2 && (i % W) >= 2) exp_conv_q.push_back(p);
      if (mode == 2 && i == 5) begin
        @(posedge HCLK); #1;
        conv_done = 1'b1;
        @(posedge HCLK); #1;
        conv_done = 1'b0;
      end
      ahb_xfer(1'b1, A_PIX, {24'h0, p}, rd, st, dc);
      if (mode == 1 && i == 11) begin
        check("stall_seen", 32'(st != 0), 32'h1);
        check("stall_release_cycle", 32'(dc), 32'(done_cycle + 1));
      end
      if (mode == 2 && i == 10) begin
        ahb_xfer(1'b0, A_STAT, 32'h0, rd, st, dc);
        ahb_xfer(1'b1, A_CTRL, 32'h1, rd, st, dc);
        check("ctrl_no_stall", 32'(st), 32'h0);
        ahb_xfer(1'b0, A_STAT, 32'h0, rd, st, dc);
        check("status_in_wait_done", rd, 32'h0001_0001);
      end
    end
    for (int k = 0; k < 200 && !frame_done; k++) @(posedge HCLK);
    #1;
    check("frame_done", {31'h0, frame_done}, 32'h1);
    ahb_xfer(1'b0, A_STAT, 32'h0, rd, st, dc);
    check("status_end_of_frame", rd, 32'h0004_0002);
    check("pix_queue_drained", 32'(exp_pix_q.size()), 32'h0);
    check("conv_queue_drained", 32'(exp_conv_q.size()), 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rd;
    int st, dc;

    vecs[0]  = '{1'b0, A_STAT, 32'h0,  32'h0, "status_after_reset"};
    vecs[1]  = '{1'b0, A_PIX,  32'h0,  32'h0, "read_pixel_wo"};
    vecs[2]  = '{1'b0, A_CTRL, 32'h0,  32'h0, "read_ctrl_wo"};
    vecs[3]  = '{1'b1, A_PIX,  32'h55, 32'h0, "pixel_write_idle"};
    vecs[4]  = '{1'b0, A_OUT,  32'h0,  32'h0, "read_outside_window"};
    vecs[5]  = '{1'b1, A_OUT,  32'h1,  32'h0, "write_outside_window"};
    vecs[6]  = '{1'b0, A_STAT, 32'h0,  32'h0, "status_still_idle"};
    vecs[7]  = '{1'b1, A_CTRL, 32'h0,  32'h0, "ctrl_bit0_clear"};
    vecs[8]  = '{1'b0, A_STAT, 32'h0,  32'h0, "status_no_start"};
    vecs[9]  = '{1'b1, A_CTRL, 32'h1,  32'h0, "ctrl_start"};
    vecs[10] = '{1'b0, A_STAT, 32'h0,  32'h5, "status_accepting"};

    bus.HSEL = 1'b0;
    bus.HADDR = 32'h0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HWDATA = 32'h0;

    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_shift", {31'h0, shift_data}, 32'h0);
    check("rst_conv", {31'h0, convolve_start}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 11; i++) begin
      ahb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st, dc);
      check({vecs[i].name, "_stall"}, 32'(st), 32'h0);
      if (!vecs[i].wr) check(vecs[i].name, rd, vecs[i].exp_rd);
    end

    conv_delay = 3;
    run_frame(0);

    ahb_xfer(1'b1, A_PIX, 32'h77, rd, st, dc);
    check("pixel_after_done_stall", 32'(st), 32'h0);
    ahb_xfer(1'b0, A_STAT, 32'h0, rd, st, dc);
    check("status_after_late_pixel", rd, 32'h0004_0002);

    ahb_xfer(1'b1, A_CTRL, 32'h1, rd, st, dc);
    ahb_xfer(1'b0, A_STAT, 32'h0, rd, st, dc);
    check("status_restart", rd, 32'h0000_0005);
    conv_delay = 20;
    run_frame(1);

    ahb_xfer(1'b1, A_CTRL, 32'h1, rd, st, dc);
    conv_delay = 20;
    run_frame(2);

    // Mid-frame reset while the pixel after 0x0A is stalled in WAIT_DONE.
    ahb_xfer(1'b1, A_CTRL, 32'h1, rd, st, dc);
    conv_delay = 1000;
    for (int i = 0; i <= 10; i++) begin
      exp_pix_q.push_back(8'(i));
      if ((i / W) >= 2 && (i % W) >= 2) exp_conv_q.push_back(8'(i));
      ahb_xfer(1'b1, A_PIX, 32'(i), rd, st, dc);
    end
    fork
      ahb_xfer(1'b1, A_PIX, 32'h0B, rd, st, dc);
      begin
        repeat (4) @(posedge HCLK);
        #2;
        check("stalled_before_reset", {31'h0, bus.HREADYOUT}, 32'h0);
        #1 HRESETn = 1'b0;
        resp_epoch++;
        conv_done = 1'b0;
        #1;
        check("async_rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        check("async_rst_pixel_out", {24'h0, pixel_out}, 32'h0);
        check("async_rst_hrdata", bus.HRDATA, 32'h0);
        check("async_rst_hresp", {31'h0, bus.HRESP}, 32'h0);
        check("async_rst_shift_conv", {30'h0, shift_data, convolve_start}, 32'h0);
        @(posedge HCLK);
        #2 HRESETn = 1'b1;
      end
    join
    check("reset_xfer_had_stalled", 32'(st != 0), 32'h1);
    check("reset_pix_queue", 32'(exp_pix_q.size()), 32'h0);
    check("reset_conv_queue", 32'(exp_conv_q.size()), 32'h0);
    exp_pix_q.delete();
    exp_conv_q.delete();
    @(posedge HCLK); #1;
    ahb_xfer(1'b0, A_STAT, 32'h0, rd, st, dc);
    check("status_after_async_reset", rd, 32'h0);

    ahb_xfer(1'b1, A_CTRL, 32'h1, rd, st, dc);
    conv_delay = 3;
    run_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
